// File: rtl/nettlp_tx_encap.sv
// rtl/nettlp_tx_encap.sv - NetTLP Ethernet/IPv4/UDP encapsulation of RX TLPs onto the 10G TX stream
module nettlp_tx_encap #(
    parameter logic [7:0]  IP_TTL    = 8'd64,
    parameter logic [7:0]  IP_PROTO  = 8'h11,
    parameter logic [15:0] ETHERTYPE = 16'h0800
) (
    input  logic         clk156,
    input  logic         sys_rst_n,
    input  logic [106:0] fifo_dout,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [47:0]  cfg_dst_mac,
    input  logic [47:0]  cfg_src_mac,
    input  logic [31:0]  cfg_src_ip,
    input  logic [31:0]  cfg_dst_ip,
    input  logic [15:0]  cfg_src_port,
    input  logic [15:0]  cfg_dst_port,
    input  logic [31:0]  tstamp_in,
    input  logic         eth_tready,
    output logic         eth_tvalid,
    output logic [63:0]  eth_tdata,
    output logic [7:0]   eth_tkeep,
    output logic         eth_tlast,
    output logic         eth_tuser
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CSUM0   = 3'd1;
    localparam logic [2:0] CSUM1   = 3'd2;
    localparam logic [2:0] HDR     = 3'd3;
    localparam logic [2:0] PAYLOAD = 3'd4;

    // FIFO entry: {tlp_len[10:0], tvalid, tlast, tkeep[7:0], tdata[63:0], tuser[21:0]}
    logic [10:0] head_len;
    logic        head_tlast;
    logic [7:0]  head_tkeep;
    logic [63:0] head_tdata;
    logic        unused_fifo_bits;

    assign head_len         = fifo_dout[106:96];
    assign head_tlast       = fifo_dout[94];
    assign head_tkeep       = fifo_dout[93:86];
    assign head_tdata       = fifo_dout[85:22];
    assign unused_fifo_bits = ^{fifo_dout[95], fifo_dout[21:0]};

    logic [2:0]  state;
    logic [2:0]  beat;
    logic [47:0] dst_mac_q, src_mac_q;
    logic [31:0] src_ip_q, dst_ip_q, tstamp_q;
    logic [15:0] src_port_q, dst_port_q;
    logic [11:0] len_q;
    logic [15:0] id_q, id_cnt;
    logic [9:0]  seq_q, seq_cnt;
    logic [31:0] sum_q;
    logic [15:0] csum_q;

    logic [15:0]  tot_len, udp_len;
    logic [31:0]  sum_c, fold1, fold2;
    logic [383:0] hdr_be;
    logic [63:0]  hdr_chunk, hdr_beat;
    logic         accept;

    assign tot_len = 16'd34 + {4'b0, len_q};
    assign udp_len = 16'd14 + {4'b0, len_q};

    assign sum_c = 32'h0000_4500 + {16'b0, tot_len} + {16'b0, id_q} + 32'h0000_4000
                 + {16'b0, IP_TTL, IP_PROTO}
                 + {16'b0, src_ip_q[31:16]} + {16'b0, src_ip_q[15:0]}
                 + {16'b0, dst_ip_q[31:16]} + {16'b0, dst_ip_q[15:0]};

    assign fold1 = {16'b0, sum_q[15:0]} + {16'b0, sum_q[31:16]};
    assign fold2 = {16'b0, fold1[15:0]} + {16'b0, fold1[31:16]};

    // Header in network order, first wire byte in the MSBs
    assign hdr_be = {dst_mac_q, src_mac_q, ETHERTYPE,
                     8'h45, 8'h00, tot_len, id_q, 16'h4000, IP_TTL, IP_PROTO, csum_q,
                     src_ip_q, dst_ip_q,
                     src_port_q, dst_port_q, udp_len, 16'h0000,
                     6'b0, seq_q, tstamp_q};

    always_comb begin
        hdr_chunk = 64'h0;
        case (beat)
            3'd0:    hdr_chunk = hdr_be[383:320];
            3'd1:    hdr_chunk = hdr_be[319:256];
            3'd2:    hdr_chunk = hdr_be[255:192];
            3'd3:    hdr_chunk = hdr_be[191:128];
            3'd4:    hdr_chunk = hdr_be[127:64];
            3'd5:    hdr_chunk = hdr_be[63:0];
            default: hdr_chunk = 64'h0;
        endcase
        hdr_beat = 64'h0;
        for (int j = 0; j < 8; j++) begin
            hdr_beat[8*j +: 8] = hdr_chunk[63-8*j -: 8];
        end
    end

    always_comb begin
        eth_tvalid = 1'b0;
        eth_tdata  = 64'h0;
        eth_tkeep  = 8'h00;
        eth_tlast  = 1'b0;
        fifo_rd_en = 1'b0;
        if (state == HDR) begin
            eth_tvalid = 1'b1;
            eth_tdata  = hdr_beat;
            eth_tkeep  = 8'hFF;
        end else if (state == PAYLOAD) begin
            eth_tvalid = !fifo_empty;
            eth_tdata  = head_tdata;
            eth_tkeep  = head_tkeep;
            eth_tlast  = head_tlast;
            fifo_rd_en = !fifo_empty && eth_tready;
        end
    end

    assign eth_tuser = 1'b0;
    assign accept    = eth_tvalid && eth_tready;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            beat       <= 3'd0;
            dst_mac_q  <= 48'h0;
            src_mac_q  <= 48'h0;
            src_ip_q   <= 32'h0;
            dst_ip_q   <= 32'h0;
            src_port_q <= 16'h0;
            dst_port_q <= 16'h0;
            tstamp_q   <= 32'h0;
            len_q      <= 12'h0;
            id_q       <= 16'h0;
            seq_q      <= 10'h0;
            id_cnt     <= 16'h0;
            seq_cnt    <= 10'h0;
            sum_q      <= 32'h0;
            csum_q     <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        dst_mac_q  <= cfg_dst_mac;
                        src_mac_q  <= cfg_src_mac;
                        src_ip_q   <= cfg_src_ip;
                        dst_ip_q   <= cfg_dst_ip;
                        src_port_q <= cfg_src_port;
                        dst_port_q <= cfg_dst_port;
                        tstamp_q   <= tstamp_in;
                        // An 11-bit length of zero stands for the 2048-byte maximum TLP
                        len_q      <= (head_len == 11'd0) ? 12'd2048 : {1'b0, head_len};
                        id_q       <= id_cnt;
                        seq_q      <= seq_cnt;
                        state      <= CSUM0;
                    end
                end
                CSUM0: begin
                    sum_q <= sum_c;
                    state <= CSUM1;
                end
                CSUM1: begin
                    csum_q <= ~fold2[15:0];
                    beat   <= 3'd0;
                    state  <= HDR;
                end
                HDR: begin
                    if (accept) begin
                        if (beat == 3'd5) begin
                            id_cnt  <= id_cnt + 16'd1;
                            seq_cnt <= seq_cnt + 10'd1;
                            state   <= PAYLOAD;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept && head_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nettlp_tx_encap.sv
// tb/tb_nettlp_tx_encap.sv - directed vector bench for nettlp_tx_encap with a FWFT FIFO model and stream monitor
module tb_nettlp_tx_encap;
    localparam logic [47:0] DST_MAC = 48'h0011_2233_4455;
    localparam logic [47:0] SRC_MAC = 48'h0A0B_0C0D_0E0F;
    localparam logic [15:0] SPORT   = 16'h3000;
    localparam logic [15:0] DPORT   = 16'h3001;
    localparam logic [31:0] IP_A1   = 32'hC0A8_0A01;
    localparam logic [31:0] IP_A3   = 32'hC0A8_0A03;

    logic         clk156, sys_rst_n;
    logic [106:0] fifo_dout;
    logic         fifo_empty, fifo_rd_en;
    logic [31:0]  cfg_src_ip, cfg_dst_ip, tstamp_in;
    logic         eth_tready, eth_tvalid, eth_tlast, eth_tuser;
    logic [63:0]  eth_tdata;
    logic [7:0]   eth_tkeep;

    nettlp_tx_encap dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .cfg_dst_mac(DST_MAC), .cfg_src_mac(SRC_MAC),
        .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
        .cfg_src_port(SPORT), .cfg_dst_port(DPORT),
        .tstamp_in(tstamp_in),
        .eth_tready(eth_tready), .eth_tvalid(eth_tvalid), .eth_tdata(eth_tdata),
        .eth_tkeep(eth_tkeep), .eth_tlast(eth_tlast), .eth_tuser(eth_tuser)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    typedef struct {
        logic [10:0] len;
        int          nb;
        logic [7:0]  lk;
        logic [31:0] sip;
        logic [31:0] dip;
        bit          tog;
        logic [15:0] tot;
        logic [15:0] udp;
        logic [15:0] csum;
    } vec_t;

    logic [106:0] fq[$];
    beat_t        cap[$];
    int           start_q[$], end_q[$];
    int           n_cmp = 0, n_bad = 0;
    int           bad_pop = 0, stab_err = 0, cyc = 0;
    bit           toggle_mode = 0;

    initial begin
        clk156 = 0;
        forever #5 clk156 = ~clk156;
    end

    task automatic update_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = fifo_empty ? 107'h0 : fq[0];
    endtask

    always @(posedge clk156) begin
        #1;
        tstamp_in = tstamp_in + 32'h0001_0003;
        eth_tready = toggle_mode ? ~eth_tready : 1'b1;
    end

    // FIFO pops on the edge that follows a sampled fifo_rd_en
    initial begin
        bit p;
        forever begin
            @(negedge clk156);
            p = fifo_rd_en;
            @(posedge clk156);
            #1;
            if (p) begin
                if (fq.size() == 0) bad_pop++;
                else void'(fq.pop_front());
                update_fifo();
            end
        end
    end

    initial begin
        int  bi = 0;
        bit  started = 0, prev_stall = 0;
        beat_t prev, cur;
        forever begin
            @(negedge clk156);
            cyc++;
            if (!sys_rst_n) begin
                bi = 0; started = 0; prev_stall = 0;
            end else begin
                cur = '{d: eth_tdata, k: eth_tkeep, l: eth_tlast};
                if (eth_tvalid && bi == 0 && !started) begin
                    start_q.push_back(cyc);
                    started = 1;
                end
                if (prev_stall && (!eth_tvalid || cur != prev)) stab_err++;
                prev_stall = eth_tvalid && !eth_tready;
                prev = cur;
                if (eth_tvalid && eth_tready) begin
                    cap.push_back(cur);
                    if ((bi < 6 && fifo_rd_en) || (bi >= 6 && !fifo_rd_en)) bad_pop++;
                    if (eth_tlast) begin
                        end_q.push_back(cyc);
                        bi = 0; started = 0;
                    end else begin
                        bi++;
                    end
                end else if (fifo_rd_en) begin
                    bad_pop++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_tlp(input logic [10:0] len, input int nb, input logic [7:0] lk, input logic [15:0] tag);
        for (int k = 0; k < nb; k++) begin
            fq.push_back({len, 1'b1, (k == nb - 1), (k == nb - 1) ? lk : 8'hFF,
                          16'hC0DE, tag, 16'h0000, 16'(k), 22'h0});
        end
        update_fifo();
    endtask

    function automatic logic [15:0] ref_csum(input logic [15:0] tot, input logic [15:0] id,
                                             input logic [31:0] s, input logic [31:0] d);
        logic [15:0] w[10];
        logic [16:0] acc;
        w = '{16'h4500, tot, id, 16'h4000, 16'h4011, s[31:16], s[15:0], d[31:16], d[15:0], 16'h0};
        acc = 17'h0;
        for (int i = 0; i < 10; i++) begin
            acc = {1'b0, acc[15:0]} + {1'b0, w[i]};
            acc = {1'b0, acc[15:0]} + {16'h0, acc[16]};
        end
        return ~acc[15:0];
    endfunction

    task automatic wait_beats(input int n, output bit ok);
        int t = 0;
        while (cap.size() < n && t < 3000) begin
            @(posedge clk156);
            #2;
            t++;
        end
        ok = (cap.size() >= n);
        if (!ok) chk("beat_timeout", 128'(cap.size()), 128'(n));
    endtask

    task automatic check_frame(input string nm, input logic [15:0] tot, input logic [15:0] udp,
                               input logic [15:0] id, input logic [15:0] csum,
                               input logic [31:0] sip, input logic [31:0] dip,
                               input logic [9:0] seq, input logic [31:0] ts, input bit chk_ts,
                               input int nb, input logic [7:0] lk, input logic [15:0] tag,
                               output bit ok);
        logic [383:0] h;
        logic [63:0]  e, m;
        beat_t        b;
        wait_beats(6 + nb, ok);
        if (!ok) return;
        h = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot, id, 16'h4000, 8'd64, 8'h11, csum,
             sip, dip, SPORT, DPORT, udp, 16'h0000, 6'b0, seq, ts};
        for (int i = 0; i < 6; i++) begin
            b = cap.pop_front();
            for (int j = 0; j < 8; j++) e[8*j +: 8] = h[383 - 8*(8*i + j) -: 8];
            m = (i == 5 && !chk_ts) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            chk($sformatf("%s_hdr%0d", nm, i), {b.d & m, b.k, b.l}, {e & m, 8'hFF, 1'b0});
        end
        for (int k = 0; k < nb; k++) begin
            b = cap.pop_front();
            chk($sformatf("%s_pl%0d", nm, k), {b.d, b.k, b.l},
                {16'hC0DE, tag, 16'h0000, 16'(k), (k == nb - 1) ? lk : 8'hFF, (k == nb - 1)});
        end
    endtask

    vec_t    vt[4];
    bit      ok;
    int      push_cyc;
    logic [31:0] ts;

    initial begin
        vt[0] = '{len: 11'd12, nb: 2,   lk: 8'h0F, sip: IP_A1, dip: IP_A3,
                  tog: 1, tot: 16'h002E, udp: 16'h001A, csum: 16'hA568};
        vt[1] = '{len: 11'd0,  nb: 256, lk: 8'hFF, sip: 32'h0A00_0001, dip: 32'h0A00_0002,
                  tog: 0, tot: 16'h0822, udp: 16'h080E, csum: 16'h1EC6};
        vt[2] = '{len: 11'd24, nb: 3,   lk: 8'hFF, sip: 32'hAC10_0005, dip: 32'hAC10_0009,
                  tog: 1, tot: 16'h003A, udp: 16'h0026, csum: 16'hE280};
        vt[3] = '{len: 11'd4,  nb: 1,   lk: 8'h0F, sip: IP_A1, dip: IP_A3,
                  tog: 0, tot: 16'h0026, udp: 16'h0012, csum: 16'hA56D};

        sys_rst_n = 0; eth_tready = 1; tstamp_in = 32'h1000_0000;
        cfg_src_ip = IP_A1; cfg_dst_ip = IP_A3;
        update_fifo();
        repeat (3) @(posedge clk156);
        #2;
        chk("rst_outputs", {eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser, fifo_rd_en}, 128'h0);
        sys_rst_n = 1;

        // Back-to-back frames: latency, minimum gap, id/seq increment
        @(posedge clk156); #1;
        push_tlp(11'd12, 2, 8'h0F, 16'h0001);
        push_tlp(11'd12, 2, 8'h0F, 16'h0002);
        push_cyc = cyc + 1;
        #2 ts = tstamp_in;
        check_frame("b2b_a", 16'h002E, 16'h001A, 16'd0, 16'hA56A, IP_A1, IP_A3, 10'd0, ts, 1, 2, 8'h0F, 16'h0001, ok);
        check_frame("b2b_b", 16'h002E, 16'h001A, 16'd1, 16'hA569, IP_A1, IP_A3, 10'd1, 32'h0, 0, 2, 8'h0F, 16'h0002, ok);
        if (start_q.size() >= 2 && end_q.size() >= 1) begin
            chk("latency", 128'(start_q[0] - push_cyc), 128'd3);
            chk("frame_gap", 128'(start_q[1] - end_q[0]), 128'd4);
        end else begin
            chk("frame_marks", 128'(start_q.size()), 128'd2);
        end

        for (int v = 0; v < 4; v++) begin
            toggle_mode = vt[v].tog;
            cfg_src_ip = vt[v].sip; cfg_dst_ip = vt[v].dip;
            @(posedge clk156); #1;
            push_tlp(vt[v].len, vt[v].nb, vt[v].lk, 16'(16'h0100 + v));
            #2 ts = tstamp_in;
            check_frame($sformatf("vec%0d", v), vt[v].tot, vt[v].udp, 16'(2 + v), vt[v].csum,
                        vt[v].sip, vt[v].dip, 10'(2 + v), ts, 1, vt[v].nb, vt[v].lk,
                        16'(16'h0100 + v), ok);
            toggle_mode = 0;
        end

        // Streamed frames carry the sequence number through 1023 and back to 0
        cfg_src_ip = IP_A1; cfg_dst_ip = IP_A3;
        @(posedge clk156); #1;
        for (int i = 6; i <= 1024; i++) push_tlp(11'd4, 1, 8'h0F, 16'(i));
        for (int i = 6; i <= 1024; i++) begin
            check_frame($sformatf("seq%0d", i), 16'h0026, 16'h0012, 16'(i),
                        ref_csum(16'h0026, 16'(i), IP_A1, IP_A3), IP_A1, IP_A3,
                        10'(i % 1024), 32'h0, 0, 1, 8'h0F, 16'(i), ok);
            if (!ok) break;
        end

        // Reset while payload beat 3 is on the bus
        @(posedge clk156); #1;
        push_tlp(11'd40, 5, 8'hFF, 16'h0BAD);
        wait_beats(9, ok);
        sys_rst_n = 0;
        #1;
        chk("midrst_outputs", {eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser, fifo_rd_en}, 128'h0);
        repeat (2) @(posedge clk156);
        fq.delete(); update_fifo();
        cap.delete(); start_q.delete(); end_q.delete();
        @(posedge clk156); #2;
        sys_rst_n = 1;
        @(posedge clk156); #1;
        push_tlp(11'd12, 2, 8'h0F, 16'h5151);
        #2 ts = tstamp_in;
        check_frame("post_rst", 16'h002E, 16'h001A, 16'd0, 16'hA56A, IP_A1, IP_A3, 10'd0, ts, 1, 2, 8'h0F, 16'h5151, ok);

        repeat (4) @(posedge clk156);
        chk("rd_en_discipline", 128'(bad_pop), 128'd0);
        chk("stall_stability", 128'(stab_err), 128'd0);
        chk("leftover_beats", 128'(cap.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
